// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, word width and sequencer state type
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_AND = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mp_sequencer.sv
// rtl/alu_mp_sequencer.sv - multi-precision word sequencer in front of the 32-bit ALU
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, op, cin, a, b    request and wide operands (sampled when not busy)
//   busy, done              words being issued / one-cycle completion pulse
//   result, carry_out, zero wide result and flags, valid with done, then held
//   alu_a, alu_b, alu_c     current word pair and chained carry to the ALU
//   alu_ctrl                latched op code to the ALU
//   alu_out, alu_c_out      combinational ALU result and carry/borrow out
module alu_mp_sequencer
    import alu_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int W      = 32 * NWORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             carry_out,
    output logic             zero,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic             alu_c,
    output logic [1:0]       alu_ctrl,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_c_out
);

    localparam int               IDX_W    = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_zero_nxt;
    logic             w_arith_in;

    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [1:0]       r_op;
    logic             r_carry_out;
    logic             r_zero;
    logic [ALU_W-1:0] r_a_w   [NWORDS];
    logic [ALU_W-1:0] r_b_w   [NWORDS];
    logic [ALU_W-1:0] r_res_w [NWORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_idx == IDX_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Carry-in only seeds ADD/SUB; logic ops start the chain at 0.
    assign w_arith_in = (op == ALU_ADD) || (op == ALU_SUB);

    // At the last edge every lower word has already been written by this run,
    // so zero can be resolved from the stored words plus the live top word.
    always_comb begin
        w_zero_nxt = (alu_out == '0);
        for (int i = 0; i < NWORDS - 1; i++) begin
            if (r_res_w[i] != '0) begin
                w_zero_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_op        <= ALU_ADD;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                r_a_w[i]   <= '0;
                r_b_w[i]   <= '0;
                r_res_w[i] <= '0;
            end
        end else if (w_accept) begin
            r_idx   <= '0;
            r_op    <= op;
            r_carry <= w_arith_in ? cin : 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                r_a_w[i] <= a[ALU_W*i +: ALU_W];
                r_b_w[i] <= b[ALU_W*i +: ALU_W];
            end
        end else if (r_state == RUN) begin
            r_res_w[r_idx] <= alu_out;
            r_carry        <= alu_c_out;
            if (w_last) begin
                r_carry_out <= ((r_op == ALU_OR) || (r_op == ALU_AND)) ? 1'b0 : alu_c_out;
                r_zero      <= w_zero_nxt;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign carry_out = r_carry_out;
    assign zero      = r_zero;
    assign alu_a     = busy ? r_a_w[r_idx] : '0;
    assign alu_b     = busy ? r_b_w[r_idx] : '0;
    assign alu_c     = busy ? r_carry : 1'b0;
    assign alu_ctrl  = r_op;

    for (genvar g = 0; g < NWORDS; g++) begin : g_result
        assign result[ALU_W*g +: ALU_W] = r_res_w[g];
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb/tb_alu_mp_sequencer.sv - scoreboard bench for alu_mp_sequencer with a behavioural ALU
module tb_alu_mp_sequencer;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic          cin = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          zero;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic          alu_c;
    logic [1:0]    alu_ctrl;
    logic [31:0]   alu_out;
    logic          alu_c_out;
    logic [32:0]   alu_t;

    alu_mp_sequencer #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_c_out (alu_c_out)
    );

    // Reference 32-bit ALU: c_out is carry for ADD, borrow for SUB, 0 for logic ops.
    always_comb begin
        alu_t = '0;
        case (alu_ctrl)
            2'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_c};
            2'd1:    alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_c};
            2'd2:    alu_t = {1'b0, alu_a | alu_b};
            default: alu_t = {1'b0, alu_a & alu_b};
        endcase
        alu_out   = alu_t[31:0];
        alu_c_out = alu_t[32];
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         co;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_carry"}, W'(carry_out), W'(e.co));
                chk({e.name, "_zero"}, W'(zero), W'(e.z));
                chk({e.name, "_done_cycle"}, W'(cyc), W'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: got %0d outstanding expected 0", q.size());
        q.delete();
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic ci,
                         input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] er, input logic eco, input logic ez);
        exp_t e;
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = o; cin = ci; a = aa; b = bb;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.name = nm; e.res = er; e.co = eco; e.z = ez; e.cyc = cyc + NW;
        q.push_back(e);
        chk({nm, "_busy"}, W'(busy), W'(1));
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] PF0  = {(W/8){8'hF0}};
    localparam logic [W-1:0] P0F  = {(W/8){8'h0F}};

    initial begin
        exp_t e;
        int   c0;
        #1;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_result", result, '0);
        chk("reset_alu_a", W'(alu_a), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue("add_ripple", 2'd0, 1'b0, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1,
              128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
        issue("add_cin_wrap", 2'd0, 1'b1, ONES, '0, '0, 1'b1, 1'b1);
        issue("sub_borrow", 2'd1, 1'b0, '0, 128'd1, ONES, 1'b1, 1'b0);
        issue("sub_small", 2'd1, 1'b0, 128'd5, 128'd3, 128'd2, 1'b0, 1'b0);
        issue("or_pat", 2'd2, 1'b1, PF0, P0F, ONES, 1'b0, 1'b0);
        issue("and_pat", 2'd3, 1'b1, PF0, P0F, '0, 1'b0, 1'b1);

        // Ignored start mid-run, then start held into DONE for a back-to-back op.
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = 2'd0; cin = 1'b0; a = 128'd1; b = 128'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        e.name = "b2b_first"; e.res = 128'd3; e.co = 1'b0; e.z = 1'b0; e.cyc = c0 + NW;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b1; op = 2'd3; a = ONES; b = 128'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; op = 2'd1; cin = 1'b0; a = 128'd10; b = 128'd4;
        e.name = "b2b_second"; e.res = 128'd6; e.co = 1'b0; e.z = 1'b0; e.cyc = c0 + NW + 5;
        q.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; op = 2'd1; cin = 1'b0; a = ONES; b = 128'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, '0);
        chk("rst_carry", W'(carry_out), W'(0));
        chk("rst_alu_a", W'(alu_a), W'(0));
        chk("rst_alu_b", W'(alu_b), W'(0));
        chk("rst_alu_ctrl", W'(alu_ctrl), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue("post_reset_add", 2'd0, 1'b0, 128'h00000001_00000000_FFFFFFFF_12345678,
              128'h00000002_00000000_00000001_00000001,
              128'h00000003_00000001_00000000_12345679, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", W'(q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
